// File: rtl/pipe_adder_pkg.sv
// Shared constants and mode encoding for the segmented pipelined adder.
package pipe_adder_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEG   = 4;

endpackage

// File: rtl/seg_adder.sv
// One SEG-bit ripple segment. Also exposes the carry into its MSB so the
// final segment can derive signed overflow as cmsb ^ cout.
module seg_adder #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           cmsb
);

  logic [SEG:0] t;

  // plain add with carry; the MSB carry-in is recovered from the sum bit
  always_comb begin
    t    = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
    sum  = t[SEG-1:0];
    cout = t[SEG];
    cmsb = a[SEG-1] ^ b[SEG-1] ^ t[SEG-1];
  end

endmodule

// File: rtl/pipe_adder.sv
// Segmented ripple-carry adder, one SEG-bit segment per pipeline stage.
// Unresolved upper operand bits ride along in shrinking registers while
// resolved sum bits accumulate in growing registers, so a beat's bits all
// leave the last stage together. Subtract is folded in at the input by
// inverting b and forcing the carry-in, so the mode needs no further
// storage. One shared enable stalls every stage at once.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG;

  logic             adv;
  logic [STAGES:1]  vld_pipe;
  mode_e            mode;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  assign mode  = mode_e'(sub);
  assign b_eff = (mode == MODE_SUB) ? ~b : b;
  assign c_eff = (mode == MODE_SUB) ? 1'b1 : cin;

  assign out_valid = vld_pipe[STAGES];
  assign adv       = !(out_valid && !out_ready);
  assign in_ready  = adv;

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

  // valid shift register; a bubble enters whenever in_valid is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   vld_pipe <= '0;
    else if (adv) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    // operand bits still unresolved on entry to stage k
    localparam int AW = WIDTH - k * SEG;

    logic [AW-1:0]        av;
    logic [AW-1:0]        bv;
    logic                 cv;
    logic [SEG-1:0]       ss;
    logic                 co;
    logic                 cm;
    logic [(k+1)*SEG-1:0] snext;

    if (k == 0) begin : g_in
      assign av    = a;
      assign bv    = b_eff;
      assign cv    = c_eff;
      assign snext = ss;
    end else begin : g_mid
      assign av    = g_stg[k-1].g_reg.a_q;
      assign bv    = g_stg[k-1].g_reg.b_q;
      assign cv    = g_stg[k-1].g_reg.c_q;
      assign snext = {ss, g_stg[k-1].g_reg.s_q};
    end

    seg_adder #(.SEG(SEG)) u_seg (
      .a    (av[SEG-1:0]),
      .b    (bv[SEG-1:0]),
      .cin  (cv),
      .sum  (ss),
      .cout (co),
      .cmsb (cm)
    );

    if (k < STAGES - 1) begin : g_reg
      logic [AW-SEG-1:0]    a_q;
      logic [AW-SEG-1:0]    b_q;
      logic                 c_q;
      logic [(k+1)*SEG-1:0] s_q;

      // hand the remaining operand bits, carry and partial sum to stage k+1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
          c_q <= 1'b0;
          s_q <= '0;
        end else if (adv) begin
          a_q <= av[AW-1:SEG];
          b_q <= bv[AW-1:SEG];
          c_q <= co;
          s_q <= snext;
        end
      end
    end else begin : g_out
      // final stage: register the full result; held while stalled
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_q  <= '0;
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
        end else if (adv) begin
          sum_q  <= snext;
          cout_q <= co;
          ovf_q  <= co ^ cm;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_adder.sv
// Directed/random bench for pipe_adder with a result scoreboard.
module tb_pipe_adder;
  import pipe_adder_pkg::*;

  localparam int W   = 16;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } res_t;

  typedef struct {
    res_t r;
    int   t;
    bit   lat;
  } ent_t;

  ent_t sbq[$];
  res_t pend;
  int   checks = 0;
  int   errors = 0;
  int   tickn = 0;
  int   streak = 0;
  int   maxstreak = 0;
  bit   lat_on = 1'b0;

  pipe_adder #(.WIDTH(W), .SEG(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(logic [W-1:0] x, logic [W-1:0] y, logic ci, logic s);
    logic [W-1:0] be;
    logic [W:0]   t;
    res_t         r;
    be  = s ? ~y : y;
    t   = {1'b0, x} + {1'b0, be} + {{W{1'b0}}, (s ? 1'b1 : ci)};
    r.s = t[W-1:0];
    r.c = t[W];
    r.o = (x[W-1] == be[W-1]) && (t[W-1] != x[W-1]);
    return r;
  endfunction

  // one cycle: sample just after a falling edge, then run to the next one
  task automatic tick(output bit acc);
    ent_t e;
    #1;
    acc = in_valid && in_ready;
    if (out_valid) begin
      streak++;
      if (streak > maxstreak) maxstreak = streak;
    end else begin
      streak = 0;
    end
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("spurious_out", out_valid, 1'b0);
      end else begin
        e = sbq.pop_front();
        chk("sum", sum, e.r.s);
        chk("cout", cout, e.r.c);
        chk("ovf", ovf, e.r.o);
        if (e.lat) chk("latency", tickn - e.t, LAT);
      end
    end
    if (acc) sbq.push_back('{pend, tickn, lat_on});
    @(negedge clk);
    tickn++;
  endtask

  task automatic send(logic [W-1:0] x, logic [W-1:0] y, logic ci, logic s,
                      bit lit, res_t given);
    bit acc;
    acc = 1'b0;
    a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
    pend = lit ? given : model(x, y, ci, s);
    for (int i = 0; i < 20 && !acc; i++) tick(acc);
    chk("send_accepted", acc, 1'b1);
  endtask

  task automatic idle(int n);
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  task automatic drain();
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < 30 && sbq.size() > 0; i++) tick(acc);
    chk("drained", sbq.size(), 0);
  endtask

  initial begin
    bit           acc;
    logic [W-1:0] hs;
    logic         hc, ho;

    // reset state
    #2 rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_sum", sum, 16'h0000);
    chk("rst_cout", cout, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;

    // directed vectors, first one on the first edge after reset release
    lat_on = 1'b1;
    send(16'h1234, 16'h4321, 1'b0, MODE_ADD, 1'b1, '{16'h5555, 1'b0, 1'b0});
    idle(6);
    send(16'hFFFF, 16'h0001, 1'b0, MODE_ADD, 1'b1, '{16'h0000, 1'b1, 1'b0});
    send(16'h7FFF, 16'h0001, 1'b0, MODE_ADD, 1'b1, '{16'h8000, 1'b0, 1'b1});
    send(16'h0005, 16'h0007, 1'b1, MODE_SUB, 1'b1, '{16'hFFFE, 1'b0, 1'b0});
    send(16'h8000, 16'h0001, 1'b1, MODE_SUB, 1'b1, '{16'h7FFF, 1'b1, 1'b1});
    send(16'h8000, 16'h8000, 1'b1, MODE_ADD, 1'b1, '{16'h0001, 1'b1, 1'b1});
    drain();

    // 8 back-to-back beats, alternating add/sub
    maxstreak = 0;
    for (int i = 0; i < 8; i++)
      send(W'($urandom), W'($urandom), 1'($urandom), i[0], 1'b0, '0);
    drain();
    chk("b2b_streak", maxstreak, 8);

    // stall with a valid result at the output
    lat_on = 1'b0;
    out_ready = 1'b0;
    send(16'hA5A5, 16'h5A5A, 1'b1, MODE_ADD, 1'b0, '0);
    send(16'h0100, 16'h0200, 1'b0, MODE_SUB, 1'b0, '0);
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) tick(acc);
    chk("stall_out_valid", out_valid, 1'b1);
    hs = sum; hc = cout; ho = ovf;
    a = 16'h3333; b = 16'h1111; cin = 1'b0; sub = MODE_ADD; in_valid = 1'b1;
    pend = model(a, b, cin, sub);
    for (int i = 0; i < 3; i++) begin
      tick(acc);
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_sum", sum, hs);
      chk("stall_cout", cout, hc);
      chk("stall_ovf", ovf, ho);
    end
    out_ready = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) tick(acc);
    chk("stall_resume_accept", acc, 1'b1);
    drain();

    // reset with beats in flight
    lat_on = 1'b1;
    for (int i = 0; i < 4; i++)
      send(W'($urandom), W'($urandom), 1'($urandom), i[0], 1'b0, '0);
    in_valid = 1'b0;
    #1;
    chk("fill_out_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_sum", sum, 16'h0000);
    sbq.delete();
    idle(2);
    rst_n = 1'b1;
    maxstreak = 0;
    idle(6);
    chk("post_rst_quiet", maxstreak, 0);
    send(16'h0F0F, 16'h00F1, 1'b1, MODE_ADD, 1'b1, '{16'h1001, 1'b0, 1'b0});
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
